// File: rtl/bsg_manycore_pkg.sv
// Shared widths, packet layouts and fence states for the manycore endpoint blocks.
package bsg_manycore_pkg;

   localparam int unsigned x_cord_width_gp     = 4;
   localparam int unsigned y_cord_width_gp     = 4;
   localparam int unsigned data_width_gp       = 32;
   localparam int unsigned addr_width_gp       = 32;
   localparam int unsigned packet_width_gp     = 6 + 2*(x_cord_width_gp + y_cord_width_gp)
                                                 + data_width_gp + addr_width_gp;
   localparam int unsigned ret_packet_width_gp = x_cord_width_gp + y_cord_width_gp + 5;

   // Forward packet: destination coordinates in the low bits, sender coordinates above them.
   typedef struct packed {
      logic [5:0]                 op;
      logic [addr_width_gp-1:0]   addr;
      logic [data_width_gp-1:0]   data;
      logic [y_cord_width_gp-1:0] src_y_cord;
      logic [x_cord_width_gp-1:0] src_x_cord;
      logic [y_cord_width_gp-1:0] y_cord;
      logic [x_cord_width_gp-1:0] x_cord;
   } bsg_manycore_packet_s;

   // Return (store acknowledge) packet addressed back to the issuing tile.
   typedef struct packed {
      logic [4:0]                 pad;
      logic [y_cord_width_gp-1:0] y_cord;
      logic [x_cord_width_gp-1:0] x_cord;
   } bsg_manycore_ret_packet_s;

   typedef enum logic [1:0] {
      eIDLE  = 2'd0,
      eDRAIN = 2'd1,
      eDONE  = 2'd2
   } fence_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready FIFO; the head is dequeued with yumi_i.
module bsg_two_fifo #(
   parameter int unsigned width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] r_mem [2];
   logic               r_head;
   logic               r_tail;
   logic [1:0]         r_count;
   logic               w_enq;
   logic               w_deq;

   assign ready_o = (r_count != 2'd2);
   assign v_o     = (r_count != 2'd0);
   assign data_o  = r_mem[r_head];
   assign w_enq   = v_i & ready_o;
   assign w_deq   = yumi_i & v_o;

   // Storage needs no reset; validity is tracked by r_count.
   always_ff @(posedge clk_i) begin
      if (w_enq) begin
         r_mem[r_tail] <= data_i;
      end
   end

   // Pointer and occupancy update.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_enq) r_tail <= ~r_tail;
         if (w_deq) r_head <= ~r_head;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bsg_manycore_store_credit_gate.sv
// Buffers outgoing remote stores, meters them against an outstanding-store credit
// counter and provides a fence handshake that completes once every store is acknowledged.
module bsg_manycore_store_credit_gate
   import bsg_manycore_pkg::*;
#(
   parameter  int unsigned x_cord_width_p      = x_cord_width_gp,
   parameter  int unsigned y_cord_width_p      = y_cord_width_gp,
   parameter  int unsigned data_width_p        = data_width_gp,
   parameter  int unsigned addr_width_p        = addr_width_gp,
   parameter  int unsigned max_out_credits_p   = 16,
   localparam int unsigned packet_width_lp     = 6 + 2*(x_cord_width_p + y_cord_width_p)
                                                 + data_width_p + addr_width_p,
   localparam int unsigned ret_packet_width_lp = x_cord_width_p + y_cord_width_p + 5,
   localparam int unsigned credit_width_lp     = $clog2(max_out_credits_p + 1)
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           v_i,
   input  logic [packet_width_lp-1:0]     data_i,
   output logic                           ready_o,
   output logic                           v_o,
   output logic [packet_width_lp-1:0]     data_o,
   input  logic                           ready_i,
   input  logic                           ret_v_i,
   input  logic [ret_packet_width_lp-1:0] ret_data_i,
   output logic                           ret_ready_o,
   input  logic [x_cord_width_p-1:0]      my_x_i,
   input  logic [y_cord_width_p-1:0]      my_y_i,
   input  logic                           fence_req_i,
   output logic                           fence_done_o,
   output logic [credit_width_lp-1:0]     out_credits_o,
   output logic                           credit_err_o
);

   localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(max_out_credits_p);

   logic                       w_fifo_ready;
   logic                       w_fifo_v;
   logic [packet_width_lp-1:0] w_fifo_data;
   logic                       w_send;
   logic [x_cord_width_p-1:0]  w_ret_x;
   logic [y_cord_width_p-1:0]  w_ret_y;
   logic [4:0]                 w_unused_pad;
   logic                       w_ret_match;
   logic                       w_ret_ok;
   logic                       w_ret_bad;
   logic                       w_at_max;
   logic                       w_overflow;
   logic [credit_width_lp-1:0] w_credits_nxt;

   logic [credit_width_lp-1:0] r_credits;
   logic                       r_credit_err;
   fence_state_e               r_state;
   logic                       r_fence_done;

   // Forward buffer; the head leaves only when a credit is available.
   bsg_two_fifo #(
      .width_p (packet_width_lp)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (v_i & ready_o),
      .data_i  (data_i),
      .ready_o (w_fifo_ready),
      .v_o     (w_fifo_v),
      .data_o  (w_fifo_data),
      .yumi_i  (w_send)
   );

   assign ready_o     = w_fifo_ready & (r_state != eDRAIN) & ~reset_i;
   assign v_o         = w_fifo_v & (r_credits != '0);
   assign data_o      = w_fifo_data;
   assign w_send      = v_o & ready_i;
   assign ret_ready_o = 1'b1;

   assign w_ret_x      = ret_data_i[0 +: x_cord_width_p];
   assign w_ret_y      = ret_data_i[x_cord_width_p +: y_cord_width_p];
   assign w_unused_pad = ret_data_i[ret_packet_width_lp-1 -: 5];
   assign w_ret_match  = (w_ret_x == my_x_i) & (w_ret_y == my_y_i);
   assign w_ret_ok     = ret_v_i & w_ret_match;
   assign w_ret_bad    = ret_v_i & ~w_ret_match;
   assign w_at_max     = (r_credits == credit_max_lp);
   assign w_overflow   = w_ret_ok & ~w_send & w_at_max;

   // Next credit count: a simultaneous send and return cancel; returns saturate at max.
   always_comb begin
      w_credits_nxt = r_credits;
      if (w_send && !w_ret_ok) begin
         w_credits_nxt = r_credits - credit_width_lp'(1);
      end else if (w_ret_ok && !w_send && !w_at_max) begin
         w_credits_nxt = r_credits + credit_width_lp'(1);
      end
   end

   // Credit counter and sticky error flag (mismatched or surplus returns).
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_credits    <= credit_max_lp;
         r_credit_err <= 1'b0;
      end else begin
         r_credits <= w_credits_nxt;
         if (w_ret_bad || w_overflow) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   // Fence FSM; completion uses next-state credits so a final return this cycle counts.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state      <= eIDLE;
         r_fence_done <= 1'b0;
      end else begin
         r_fence_done <= 1'b0;
         case (r_state)
            eIDLE: begin
               if (fence_req_i) r_state <= eDRAIN;
            end
            eDRAIN: begin
               if (!w_fifo_v && (w_credits_nxt == credit_max_lp)) begin
                  r_state      <= eDONE;
                  r_fence_done <= 1'b1;
               end
            end
            eDONE:   r_state <= eIDLE;
            default: r_state <= eIDLE;
         endcase
      end
   end

   assign fence_done_o  = r_fence_done;
   assign out_credits_o = r_credits;
   assign credit_err_o  = r_credit_err;

endmodule

// File: tb/tb_bsg_manycore_store_credit_gate.sv
// Scoreboard bench: accepted packets are queued, a negedge monitor checks each send.
module tb_bsg_manycore_store_credit_gate;
   import bsg_manycore_pkg::*;

   logic clk;
   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned a_sends = 0;
   int unsigned b_sends = 0;

   bsg_manycore_packet_s     a_q [$];
   bsg_manycore_packet_s     b_q [$];
   bsg_manycore_packet_s     pkt_none;
   bsg_manycore_ret_packet_s ret_none, a_ret_ok, a_ret_badx, b_ret_ok;

   // instance A: 16 credits
   logic                         a_reset, a_v_i, a_ready_o, a_v_o, a_ready_i;
   bsg_manycore_packet_s         a_data_i;
   logic [packet_width_gp-1:0]   a_data_o;
   logic                         a_ret_v_i, a_ret_ready_o;
   bsg_manycore_ret_packet_s     a_ret_data_i;
   logic [x_cord_width_gp-1:0]   a_my_x;
   logic [y_cord_width_gp-1:0]   a_my_y;
   logic                         a_fence, a_done, a_err;
   logic [4:0]                   a_credits;

   // instance B: 2 credits
   logic                         b_reset, b_v_i, b_ready_o, b_v_o, b_ready_i;
   bsg_manycore_packet_s         b_data_i;
   logic [packet_width_gp-1:0]   b_data_o;
   logic                         b_ret_v_i, b_ret_ready_o;
   bsg_manycore_ret_packet_s     b_ret_data_i;
   logic [x_cord_width_gp-1:0]   b_my_x;
   logic [y_cord_width_gp-1:0]   b_my_y;
   logic                         b_fence, b_done, b_err;
   logic [1:0]                   b_credits;

   bsg_manycore_store_credit_gate #(.max_out_credits_p(16)) dut_a (
      .clk_i(clk), .reset_i(a_reset), .v_i(a_v_i), .data_i(a_data_i), .ready_o(a_ready_o),
      .v_o(a_v_o), .data_o(a_data_o), .ready_i(a_ready_i), .ret_v_i(a_ret_v_i),
      .ret_data_i(a_ret_data_i), .ret_ready_o(a_ret_ready_o), .my_x_i(a_my_x), .my_y_i(a_my_y),
      .fence_req_i(a_fence), .fence_done_o(a_done), .out_credits_o(a_credits),
      .credit_err_o(a_err));

   bsg_manycore_store_credit_gate #(.max_out_credits_p(2)) dut_b (
      .clk_i(clk), .reset_i(b_reset), .v_i(b_v_i), .data_i(b_data_i), .ready_o(b_ready_o),
      .v_o(b_v_o), .data_o(b_data_o), .ready_i(b_ready_i), .ret_v_i(b_ret_v_i),
      .ret_data_i(b_ret_data_i), .ret_ready_o(b_ret_ready_o), .my_x_i(b_my_x), .my_y_i(b_my_y),
      .fence_req_i(b_fence), .fence_done_o(b_done), .out_credits_o(b_credits),
      .credit_err_o(b_err));

   always #5 clk = ~clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chkn(input string nm, input logic [95:0] act, input logic [95:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bsg_manycore_packet_s mk_pkt(input int unsigned i);
      bsg_manycore_packet_s p;
      p.op         = 6'h01;
      p.addr       = 32'h1000_0000 + 32'(i * 4);
      p.data       = 32'hA5A5_0000 ^ 32'(i);
      p.src_y_cord = 4'd5;
      p.src_x_cord = 4'd3;
      p.y_cord     = 4'(i);
      p.x_cord     = 4'(i + 1);
      return p;
   endfunction

   // One A cycle: drive after the posedge, return at the following negedge.
   task automatic a_cyc(input logic v, input bsg_manycore_packet_s d, input logic rv,
                        input bsg_manycore_ret_packet_s rd, input logic fr);
      @(posedge clk); #1;
      a_v_i = v; a_data_i = d; a_ret_v_i = rv; a_ret_data_i = rd; a_fence = fr;
      @(negedge clk);
      if (a_v_i && a_ready_o) a_q.push_back(a_data_i);
   endtask

   task automatic b_cyc(input logic v, input bsg_manycore_packet_s d, input logic rv,
                        output logic acc);
      @(posedge clk); #1;
      b_v_i = v; b_data_i = d; b_ret_v_i = rv; b_ret_data_i = rv ? b_ret_ok : ret_none;
      @(negedge clk);
      acc = b_v_i && b_ready_o;
      if (acc) b_q.push_back(b_data_i);
   endtask

   // Monitor: every send must match the oldest accepted packet.
   always @(negedge clk) begin
      bsg_manycore_packet_s e;
      if (a_v_o === 1'b1 && a_ready_i === 1'b1) begin
         a_sends++;
         if (a_q.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_send: got %0h expected no packet", a_data_o);
         end else begin
            e = a_q.pop_front();
            chkn("a_data", 96'(a_data_o), 96'(e));
         end
      end
      if (b_v_o === 1'b1 && b_ready_i === 1'b1) begin
         b_sends++;
         if (b_q.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_send: got %0h expected no packet", b_data_o);
         end else begin
            e = b_q.pop_front();
            chkn("b_data", 96'(b_data_o), 96'(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic acc;
      int unsigned n;
      int unsigned guard;
      clk = 1'b0;
      pkt_none   = '0;
      ret_none   = '0;
      a_ret_ok   = '{pad: 5'd0, y_cord: 4'd5, x_cord: 4'd3};
      a_ret_badx = '{pad: 5'd0, y_cord: 4'd5, x_cord: 4'd4};
      b_ret_ok   = '{pad: 5'd0, y_cord: 4'd2, x_cord: 4'd1};
      a_reset = 1'b1; a_v_i = 1'b0; a_data_i = pkt_none; a_ready_i = 1'b0;
      a_ret_v_i = 1'b0; a_ret_data_i = ret_none; a_my_x = 4'd3; a_my_y = 4'd5; a_fence = 1'b0;
      b_reset = 1'b1; b_v_i = 1'b0; b_data_i = pkt_none; b_ready_i = 1'b0;
      b_ret_v_i = 1'b0; b_ret_data_i = ret_none; b_my_x = 4'd1; b_my_y = 4'd2; b_fence = 1'b0;

      // reset state
      a_cyc(0, pkt_none, 0, ret_none, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chk1("rst_ready", a_ready_o, 1'b0);
      chk1("rst_v", a_v_o, 1'b0);
      chkn("rst_credits", 96'(a_credits), 96'(16));
      chk1("rst_err", a_err, 1'b0);
      chk1("rst_done", a_done, 1'b0);
      chk1("ret_ready", a_ret_ready_o, 1'b1);
      a_reset = 1'b0;
      a_ready_i = 1'b1;
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chk1("idle_ready", a_ready_o, 1'b1);

      // three packets, no returns
      for (int i = 0; i < 3; i++) a_cyc(1, mk_pkt(i), 0, ret_none, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t1_credits", 96'(a_credits), 96'(13));
      chkn("t1_sends", 96'(a_sends), 96'(3));
      chk1("t1_v", a_v_o, 1'b0);

      // eight more packets bring credits to 5
      for (int i = 3; i < 11; i++) a_cyc(1, mk_pkt(i), 0, ret_none, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t3_pre_credits", 96'(a_credits), 96'(5));

      // send and matching return in the same cycle
      a_cyc(1, mk_pkt(11), 0, ret_none, 0);
      a_cyc(0, pkt_none, 1, a_ret_ok, 0);
      chk1("t3_v_with_ret", a_v_o, 1'b1);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t3_credits", 96'(a_credits), 96'(5));
      chk1("t3_err", a_err, 1'b0);

      // nine returns leave two stores outstanding
      for (int i = 0; i < 9; i++) a_cyc(0, pkt_none, 1, a_ret_ok, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t4_pre_credits", 96'(a_credits), 96'(14));

      // fence with two outstanding; request dropped mid-drain, returns on cycles 10 and 14
      for (int c = 0; c < 18; c++) begin
         a_cyc(0, pkt_none, (c == 10 || c == 14), a_ret_ok, (c < 3));
         chk1($sformatf("t4_ready_c%0d", c), a_ready_o, (c >= 1 && c <= 14) ? 1'b0 : 1'b1);
         chk1($sformatf("t4_done_c%0d", c), a_done, (c == 15) ? 1'b1 : 1'b0);
      end
      chkn("t4_credits", 96'(a_credits), 96'(16));

      // fence with nothing outstanding completes one cycle after entering drain
      for (int c = 0; c < 4; c++) begin
         a_cyc(0, pkt_none, 0, ret_none, (c == 0));
         chk1($sformatf("fe_done_c%0d", c), a_done, (c == 2) ? 1'b1 : 1'b0);
      end

      // surplus return at max credits
      a_cyc(0, pkt_none, 1, a_ret_ok, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t6_credits", 96'(a_credits), 96'(16));
      chk1("t6_err", a_err, 1'b1);
      a_reset = 1'b1;
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chk1("t6_rst_err", a_err, 1'b0);
      chkn("t6_rst_credits", 96'(a_credits), 96'(16));
      a_reset = 1'b0;
      a_cyc(0, pkt_none, 0, ret_none, 0);

      // coordinate mismatch on return
      a_cyc(1, mk_pkt(12), 0, ret_none, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      a_cyc(0, pkt_none, 1, a_ret_badx, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t5_credits", 96'(a_credits), 96'(15));
      chk1("t5_err", a_err, 1'b1);
      for (int i = 0; i < 3; i++) a_cyc(0, pkt_none, 0, ret_none, 0);
      chk1("t5_err_held", a_err, 1'b1);
      a_cyc(0, pkt_none, 1, a_ret_ok, 0);
      a_cyc(0, pkt_none, 0, ret_none, 0);
      chkn("t5_credits_back", 96'(a_credits), 96'(16));
      chk1("t5_err_still", a_err, 1'b1);
      chkn("a_queue_drained", 96'(a_q.size()), 96'(0));

      // instance B: two credits, four packets offered
      b_cyc(0, pkt_none, 0, acc);
      chkn("b_rst_credits", 96'(b_credits), 96'(2));
      b_reset = 1'b0;
      b_ready_i = 1'b1;
      n = 0;
      guard = 0;
      while (n < 4 && guard < 20) begin
         b_cyc(1, mk_pkt(100 + n), 0, acc);
         if (acc) n++;
         guard++;
      end
      chkn("t2_accepted", 96'(n), 96'(4));
      b_cyc(0, pkt_none, 0, acc);
      chk1("t2_ready_full", b_ready_o, 1'b0);
      chk1("t2_v_blocked", b_v_o, 1'b0);
      chkn("t2_sends", 96'(b_sends), 96'(2));
      chkn("t2_credits", 96'(b_credits), 96'(0));
      b_cyc(0, pkt_none, 1, acc);
      for (int i = 0; i < 3; i++) b_cyc(0, pkt_none, 0, acc);
      chkn("t2_sends_after_ret", 96'(b_sends), 96'(3));
      chkn("t2_credits_after", 96'(b_credits), 96'(0));
      chk1("t2_v_after", b_v_o, 1'b0);
      chk1("t2_ready_after", b_ready_o, 1'b1);
      chkn("t2_left_in_fifo", 96'(b_q.size()), 96'(1));
      chk1("t2_err", b_err, 1'b0);
      chk1("t2_done", b_done, 1'b0);
      chk1("t2_ret_ready", b_ret_ready_o, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
